// File: rtl/pcm_to_pdm.sv
// PDM microphone emulator: buffers unsigned PCM samples in a small FIFO and
// turns each one into a 1-bit first-order sigma-delta stream with its own pdm_clk.
module pcm_to_pdm #(
  parameter int BIT_WIDTH          = 8,
  parameter int PDM_CLK_DEC_FACTOR = 12,
  parameter int OSR                = 128,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [BIT_WIDTH-1:0]          pcm_data,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pdm_clk,
  output logic                          pdm,
  output logic                          sample_tick,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (PDM_CLK_DEC_FACTOR > 1) ? $clog2(PDM_CLK_DEC_FACTOR) : 1;
  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PDM_CLK_DEC_FACTOR - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // One modulator step: the carry out of acc + sample is the PDM bit.
  function automatic logic [BIT_WIDTH:0] sd_sum(input logic [BIT_WIDTH-1:0] acc_in,
                                                input logic [BIT_WIDTH-1:0] smp_in);
    return {1'b0, acc_in} + {1'b0, smp_in};
  endfunction

  logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;
  logic                 fifo_empty;
  logic [BIT_WIDTH-1:0] fifo_head;
  logic                 push;
  logic                 pop;

  logic                 en_p1;
  logic [DIV_W-1:0]     div;
  logic                 div_last;
  logic                 start_evt;
  logic                 fall_evt;
  logic                 bit_evt;

  logic [CNT_W-1:0]     bit_cnt;
  logic [BIT_WIDTH-1:0] acc;
  logic [BIT_WIDTH-1:0] sample_q;
  logic                 frame_start;
  logic [BIT_WIDTH-1:0] mod_in;
  logic                 underrun_set;

  assign fifo_empty = (level == '0);
  assign fifo_head  = mem[rd_ptr];
  assign pcm_ready  = (level != LVL_FULL);
  assign fifo_level = level;
  assign push       = pcm_valid & pcm_ready;

  // A start event has pdm_clk low by construction, so only a real falling edge
  // of pdm_clk can qualify as fall_evt.
  assign div_last     = (div == DIV_LAST);
  assign start_evt    = enable & ~en_p1;
  assign fall_evt     = enable & en_p1 & div_last & pdm_clk;
  assign bit_evt      = start_evt | fall_evt;
  assign frame_start  = (bit_cnt == '0);
  assign pop          = bit_evt & frame_start & ~fifo_empty;
  assign underrun_set = bit_evt & frame_start & fifo_empty;
  assign mod_in       = (frame_start && !fifo_empty) ? fifo_head : sample_q;

  // FIFO storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pcm_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // pdm_clk divider; held at zero on the start event so the first rise lands
  // a full half-period after the first bit is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_p1   <= 1'b0;
      div     <= '0;
      pdm_clk <= 1'b0;
    end else begin
      en_p1 <= enable;
      if (!enable) begin
        div     <= '0;
        pdm_clk <= 1'b0;
      end else if (start_evt) begin
        div <= '0;
      end else if (div_last) begin
        div     <= '0;
        pdm_clk <= ~pdm_clk;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Sigma-delta modulator and frame sequencing, advanced once per bit event.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      acc         <= '0;
      sample_q    <= '0;
      pdm         <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      if (!enable) begin
        bit_cnt <= '0;
        acc     <= '0;
        pdm     <= 1'b0;
      end else if (bit_evt) begin
        if (frame_start) begin
          sample_tick <= 1'b1;
          if (!fifo_empty) begin
            sample_q <= fifo_head;
          end
        end
        {pdm, acc} <= sd_sum(acc, mod_in);
        bit_cnt    <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // Sticky underrun flag; a new underrun outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_to_pdm.sv
// Directed bench for pcm_to_pdm: expected PDM bits and frame-start positions are
// queued as samples are issued; a negedge monitor pops and compares them.
module tb_pcm_to_pdm;
  localparam int BW    = 8;
  localparam int F     = 12;
  localparam int OSR   = 128;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [BW-1:0] pcm_data;
  logic          pcm_valid;
  logic          pcm_ready;
  logic [2:0]    fifo_level;
  logic          pdm_clk;
  logic          pdm;
  logic          sample_tick;
  logic          underrun;
  logic          underrun_clr;

  pcm_to_pdm #(
    .BIT_WIDTH(BW), .PDM_CLK_DEC_FACTOR(F), .OSR(OSR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pcm_data(pcm_data),
    .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .fifo_level(fifo_level),
    .pdm_clk(pdm_clk), .pdm(pdm), .sample_tick(sample_tick),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_bits[$];
  int exp_ticks[$];
  int bits_seen = 0;
  int ones_seen = 0;
  int tot = 0;
  int cyc = 0;
  int last_change = 0;
  int last_rise = 0;
  int min_stable = 1000000;
  logic prev_pdm = 1'b0;
  logic prev_pdm_clk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected bits of n PDM periods at sample s, continuing the running total.
  task automatic push_frame(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      int b;
      b = ((tot + s) / 256) - (tot / 256);
      exp_bits.push_back(b[0]);
      tot += s;
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: frame-start position on each sample_tick, pdm value on each pdm_clk rise.
  always @(negedge clk) begin
    if (sample_tick === 1'b1) begin
      if (exp_ticks.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tick_unexpected: tick at bit %0d, none expected", bits_seen);
      end else begin
        check("tick_pos", bits_seen, exp_ticks.pop_front());
      end
    end
    if (pdm !== prev_pdm) last_change = cyc;
    if (pdm_clk === 1'b1 && prev_pdm_clk === 1'b0) begin
      if (cyc - last_change < min_stable) min_stable = cyc - last_change;
      if (bits_seen >= 1 && bits_seen <= 9) check("pdm_clk_period", cyc - last_rise, 2 * F);
      last_rise = cyc;
      if (exp_bits.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pdm_unexpected: rise %0d got %0d, no bit expected", bits_seen, pdm);
      end else begin
        check("pdm_bit", 32'(pdm), 32'(exp_bits.pop_front()));
      end
      bits_seen++;
      ones_seen += int'(pdm);
    end
    prev_pdm     = pdm;
    prev_pdm_clk = pdm_clk;
  end

  task automatic fifo_push(input logic [BW-1:0] d);
    int t = 0;
    @(negedge clk);
    pcm_data  = d;
    pcm_valid = 1'b1;
    while (pcm_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", 32'(pcm_ready), 1);
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic wait_bits(input int target);
    int t = 0;
    while (bits_seen < target && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("wait_bits", bits_seen, target);
    @(negedge clk);
  endtask

  task automatic wait_tick(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (sample_tick !== 1'b1 && t < 4000);
    check(name, 32'(sample_tick), 1);
  endtask

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation did not finish, bits_seen %0d", bits_seen);
    $fatal(1);
  end

  initial begin
    int n;
    int ones_ref;
    rst = 1'b1; enable = 1'b0; pcm_valid = 1'b0; pcm_data = '0; underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_pdm_clk", 32'(pdm_clk), 0);
    check("rst_pdm", 32'(pdm), 0);
    check("rst_sample_tick", 32'(sample_tick), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_pcm_ready", 32'(pcm_ready), 1);

    // Frames: 0x80, 0x00, 0xFF, then two underrun frames repeating 0xFF.
    push_frame(8'h80, OSR); exp_ticks.push_back(0);   fifo_push(8'h80);
    push_frame(8'h00, OSR); exp_ticks.push_back(128); fifo_push(8'h00);
    push_frame(8'hFF, OSR); exp_ticks.push_back(256); fifo_push(8'hFF);
    check("level_after_3", 32'(fifo_level), 3);
    push_frame(8'hFF, OSR); exp_ticks.push_back(384);
    push_frame(8'hFF, OSR); exp_ticks.push_back(512);

    @(negedge clk);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pdm_clk !== 1'b1 && n < 100);
    check("first_rise_latency", n - 1, F);

    wait_bits(128);
    check("ones_0x80", ones_seen, 64);
    wait_bits(256);
    check("ones_0x00", ones_seen, 64);
    wait_bits(384);
    check("ones_0xFF", ones_seen, 64 + 127);
    check("underrun_before", 32'(underrun), 0);
    check("level_empty", 32'(fifo_level), 0);

    wait_tick("tick_underrun_frame");
    @(negedge clk);
    check("underrun_set", 32'(underrun), 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 0);

    // Clear held across the next empty frame start: the set must win.
    wait_bits(512);
    underrun_clr = 1'b1;
    wait_tick("tick_set_wins_frame");
    underrun_clr = 1'b0;
    @(negedge clk);
    check("underrun_set_wins", 32'(underrun), 1);

    // 0x40 frame cut off by enable=0 after 50 bits.
    push_frame(8'h40, 50); exp_ticks.push_back(640);
    fifo_push(8'h40);
    wait_bits(690);
    enable = 1'b0;
    @(negedge clk);
    check("disable_pdm_clk", 32'(pdm_clk), 0);
    check("disable_pdm", 32'(pdm), 0);

    // Re-enable: fresh sample, accumulator and bit counter from zero.
    tot = 0;
    push_frame(8'hC0, OSR); exp_ticks.push_back(690);
    fifo_push(8'hC0);
    check("level_before_reenable", 32'(fifo_level), 1);
    ones_ref = ones_seen;
    @(negedge clk);
    enable = 1'b1;
    wait_bits(818);
    enable = 1'b0;
    check("ones_0xC0", ones_seen - ones_ref, 96);

    // FIFO fill with enable=0 and valid held: four accepted, fifth stalls.
    @(negedge clk);
    pcm_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pcm_data = 8'(17 * (i + 1));
      @(negedge clk);
    end
    pcm_data = 8'h55;
    repeat (3) @(negedge clk);
    check("full_pcm_ready", 32'(pcm_ready), 0);
    check("full_level", 32'(fifo_level), 4);
    exp_ticks.push_back(818);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("level_after_pop", 32'(fifo_level), 3);
    check("ready_after_pop", 32'(pcm_ready), 1);
    @(negedge clk);
    check("level_after_held_push", 32'(fifo_level), 4);

    // Reset mid-operation with pcm_valid high in the reset cycle.
    exp_ticks.push_back(818);
    pcm_data = 8'h66;
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pcm_valid = 1'b0;
    enable = 1'b0;
    check("midrst_level", 32'(fifo_level), 0);
    check("midrst_ready", 32'(pcm_ready), 1);
    check("midrst_underrun", 32'(underrun), 0);
    check("midrst_pdm_clk", 32'(pdm_clk), 0);
    check("midrst_sample_tick", 32'(sample_tick), 0);
    repeat (2) @(negedge clk);

    check("pdm_setup_ok", 32'(min_stable >= F), 1);
    check("bits_left", exp_bits.size(), 0);
    check("ticks_left", exp_ticks.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
